// File: rtl/ntt_coef_loader.sv
// Streams 16-bit coefficients into the Kyber NTT core input RAM two at a time,
// reducing each into [0,Q), then kicks the core and waits for it to finish.
module ntt_coef_loader #(
   parameter int N  = 256,
   parameter int Q  = 3329,
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_go,
   input  logic          cmd_mode,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          we,
   output logic [AW-1:0] address_ina,
   output logic [AW-1:0] address_inb,
   output logic [DW-1:0] data_ina,
   output logic [DW-1:0] data_inb,
   output logic          start,
   output logic          mode,
   input  logic          core_done,
   output logic          busy,
   output logic          err_range,
   output logic          err_len
);

   typedef enum logic [2:0] {IDLE, LOAD, PAD, KICK, WAIT} state_t;

   localparam logic [DW:0]   Q1        = (DW+1)'(Q);
   localparam logic [DW:0]   Q2        = (DW+1)'(2*Q);
   localparam logic [AW-1:0] LAST      = AW'(N-1);
   localparam logic [AW-1:0] PAIR_LAST = AW'(N-2);

   state_t        state, state_nxt;
   logic [AW-1:0] idx, idx_nxt;
   logic [DW-1:0] hold, hold_nxt;
   logic          s_ready_nxt, we_nxt, start_nxt, mode_nxt, busy_nxt;
   logic          err_range_nxt, err_len_nxt;
   logic [AW-1:0] addr_a_nxt, addr_b_nxt;
   logic [DW-1:0] data_a_nxt, data_b_nxt;

   logic [DW:0]   x_ext, x_sub;
   logic [DW-1:0] r;
   logic          over_q, accept;

   // Single conditional subtract; anything at or above 2Q is out of contract and stored as 0.
   always_comb begin
      x_ext  = {1'b0, s_data};
      x_sub  = x_ext - Q1;
      over_q = (x_ext >= Q1);
      if (x_ext >= Q2)  r = '0;
      else if (over_q)  r = x_sub[DW-1:0];
      else              r = s_data;
   end

   assign accept = (state == LOAD) && s_valid && s_ready;

   always_comb begin
      // NOTE: every next-value gets a default first so no path through the case can infer a latch.
      state_nxt     = state;
      idx_nxt       = idx;
      hold_nxt      = hold;
      we_nxt        = 1'b0;
      addr_a_nxt    = address_ina;
      addr_b_nxt    = address_inb;
      data_a_nxt    = data_ina;
      data_b_nxt    = data_inb;
      start_nxt     = 1'b0;
      mode_nxt      = mode;
      err_range_nxt = err_range;
      err_len_nxt   = err_len;

      unique case (state)
         IDLE: begin
            if (cmd_go) begin
               state_nxt     = LOAD;
               mode_nxt      = cmd_mode;
               err_range_nxt = 1'b0;
               err_len_nxt   = 1'b0;
               idx_nxt       = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               idx_nxt = idx + AW'(1);
               if (over_q) err_range_nxt = 1'b1;
               if (!idx[0]) begin
                  hold_nxt = r;
                  // Early last on an even slot: close the pair with a zero partner.
                  if (s_last) begin
                     we_nxt      = 1'b1;
                     addr_a_nxt  = idx;
                     addr_b_nxt  = idx | AW'(1);
                     data_a_nxt  = r;
                     data_b_nxt  = '0;
                     err_len_nxt = 1'b1;
                     idx_nxt     = idx + AW'(2);
                     state_nxt   = (idx == PAIR_LAST) ? KICK : PAD;
                  end
               end else begin
                  we_nxt     = 1'b1;
                  addr_a_nxt = {idx[AW-1:1], 1'b0};
                  addr_b_nxt = idx;
                  data_a_nxt = hold;
                  data_b_nxt = r;
                  if (idx == LAST) begin
                     state_nxt = KICK;
                     if (!s_last) err_len_nxt = 1'b1;
                  end else if (s_last) begin
                     err_len_nxt = 1'b1;
                     state_nxt   = PAD;
                  end
               end
            end
         end
         PAD: begin
            we_nxt     = 1'b1;
            addr_a_nxt = idx;
            addr_b_nxt = idx | AW'(1);
            data_a_nxt = '0;
            data_b_nxt = '0;
            idx_nxt    = idx + AW'(2);
            if (idx == PAIR_LAST) state_nxt = KICK;
         end
         KICK: begin
            start_nxt = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (core_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      s_ready_nxt = (state_nxt == LOAD);
      busy_nxt    = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= '0;
         hold        <= '0;
         s_ready     <= 1'b0;
         we          <= 1'b0;
         address_ina <= '0;
         address_inb <= '0;
         data_ina    <= '0;
         data_inb    <= '0;
         start       <= 1'b0;
         mode        <= 1'b0;
         busy        <= 1'b0;
         err_range   <= 1'b0;
         err_len     <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every register samples the pre-edge values of the others.
         state       <= state_nxt;
         idx         <= idx_nxt;
         hold        <= hold_nxt;
         s_ready     <= s_ready_nxt;
         we          <= we_nxt;
         address_ina <= addr_a_nxt;
         address_inb <= addr_b_nxt;
         data_ina    <= data_a_nxt;
         data_inb    <= data_b_nxt;
         start       <= start_nxt;
         mode        <= mode_nxt;
         busy        <= busy_nxt;
         err_range   <= err_range_nxt;
         err_len     <= err_len_nxt;
      end
   end

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Bench for ntt_coef_loader: scoreboard of expected RAM writes, a reduction
// vector table, and hand sequences for early/missing last, gaps and reset.
module tb_ntt_coef_loader;
   localparam int N  = 256;
   localparam int Q  = 3329;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0, rst = 1'b1;
   logic          cmd_go = 1'b0, cmd_mode = 1'b0;
   logic          s_valid = 1'b0, s_last = 1'b0, core_done = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, we, start, mode, busy, err_range, err_len;
   logic [AW-1:0] address_ina, address_inb;
   logic [DW-1:0] data_ina, data_inb;

   typedef struct packed {
      logic [AW-1:0] aa;
      logic [AW-1:0] ab;
      logic [DW-1:0] da;
      logic [DW-1:0] db;
   } wr_t;

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] r;
      logic          err;
   } vec_t;

   wr_t  exp_q[$];
   vec_t tbl[8];
   int   n_vec = 0, n_bad = 0, cycle = 0;
   int   last_we_cycle = -10, start_cycle = -10, start_cnt = 0;
   logic exp_mode = 1'b0, exp_err_range = 1'b0, exp_err_len = 1'b0;

   always #5 clk = ~clk;

   ntt_coef_loader #(.N(N), .Q(Q), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_mode(cmd_mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .we(we), .address_ina(address_ina), .address_inb(address_inb),
      .data_ina(data_ina), .data_inb(data_inb), .start(start), .mode(mode),
      .core_done(core_done), .busy(busy), .err_range(err_range), .err_len(err_len)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic logic [DW-1:0] ref_reduce(input int x);
      if (x >= 2*Q) return '0;
      if (x >= Q)   return DW'(x - Q);
      return DW'(x);
   endfunction

   // Monitor: every write must match the head of the scoreboard.
   always @(posedge clk) begin
      #1;
      cycle++;
      if (we) begin
         last_we_cycle = cycle;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL write_extra: got write at %0d/%0d, wanted none", address_ina, address_inb);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write", 64'({mode, address_ina, address_inb, data_ina, data_inb}),
                  64'({exp_mode, e.aa, e.ab, e.da, e.db}));
         end
      end
      if (start) begin
         start_cnt++;
         start_cycle = cycle;
      end
   end

   task automatic go(input logic m);
      @(negedge clk);
      cmd_go   = 1'b1;
      cmd_mode = m;
      @(negedge clk);
      cmd_go        = 1'b0;
      exp_mode      = m;
      exp_err_range = 1'b0;
      exp_err_len   = 1'b0;
      check("busy_load", 64'(busy), 64'(1));
      check("ready_load", 64'(s_ready), 64'(1));
   endtask

   // kind: 0 ramp, 1 table then ramp, 2 random values up to 3Q.
   task automatic send(input int kind, input int max_cnt, input int last_pos,
                       input int gap, input bit check_end);
      int            count, i, cyc, x;
      logic [DW-1:0] r, hold_m;
      count  = (last_pos < N && last_pos + 1 < max_cnt) ? last_pos + 1 : max_cnt;
      i      = 0;
      cyc    = 0;
      hold_m = '0;
      while (i < count && cyc < 4*N) begin
         if (s_ready && int'($urandom_range(0, 99)) >= gap) begin
            if (kind == 1 && i < 8) begin
               x = int'(tbl[i].x);
               r = tbl[i].r;
               if (tbl[i].err) exp_err_range = 1'b1;
            end else begin
               x = (kind == 2) ? int'($urandom_range(0, 3*Q)) : i;
               r = ref_reduce(x);
               if (x >= Q) exp_err_range = 1'b1;
            end
            s_valid = 1'b1;
            s_data  = DW'(x);
            s_last  = (i == last_pos);
            if (i % 2 == 1) begin
               exp_q.push_back(wr_t'{aa: AW'(i-1), ab: AW'(i), da: hold_m, db: r});
            end else begin
               hold_m = r;
               if (i == last_pos) exp_q.push_back(wr_t'{aa: AW'(i), ab: AW'(i+1), da: r, db: '0});
            end
            if (i == last_pos && i != N-1) begin
               exp_err_len = 1'b1;
               for (int p = (i | 1) + 1; p < N; p += 2)
                  exp_q.push_back(wr_t'{aa: AW'(p), ab: AW'(p+1), da: '0, db: '0});
            end
            if (i == N-1 && last_pos != N-1) exp_err_len = 1'b1;
            i++;
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("accepts", 64'(i), 64'(count));
      if (check_end) check("ready_after_last", 64'(s_ready), 64'(0));
   endtask

   task automatic finish_poly(input int done_delay, input bit poke_go, input bit done_early);
      int sc0, cyc;
      sc0 = start_cnt;
      if (done_early) core_done = 1'b1;
      cyc = 0;
      while (start_cnt == sc0 && cyc < 2*N) begin
         @(negedge clk);
         cyc++;
      end
      check("start_seen", 64'(start_cnt), 64'(sc0 + 1));
      check("start_after_we", 64'(start_cycle), 64'(last_we_cycle + 1));
      check("writes_left", 64'(exp_q.size()), 64'(0));
      check("err_range", 64'(err_range), 64'(exp_err_range));
      check("err_len", 64'(err_len), 64'(exp_err_len));
      check("ready_wait", 64'(s_ready), 64'(0));
      check("busy_wait", 64'(busy), 64'(1));
      if (done_early) begin
         @(posedge clk);
         #1;
         check("busy_done_early", 64'(busy), 64'(0));
      end else begin
         for (int k = 0; k < done_delay; k++) begin
            if (poke_go && k == 2) begin
               cmd_go   = 1'b1;
               cmd_mode = ~exp_mode;
            end else begin
               cmd_go = 1'b0;
            end
            @(negedge clk);
         end
         cmd_go = 1'b0;
         check("busy_hold", 64'(busy), 64'(1));
         check("mode_hold", 64'(mode), 64'(exp_mode));
         check("single_start", 64'(start_cnt), 64'(sc0 + 1));
         core_done = 1'b1;
         @(posedge clk);
         #1;
         check("busy_done", 64'(busy), 64'(0));
      end
      @(negedge clk);
      core_done = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, wanted finish within 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sc0;
      tbl[0] = '{x: 16'd0,     r: 16'd0,    err: 1'b0};
      tbl[1] = '{x: 16'd3328,  r: 16'd3328, err: 1'b0};
      tbl[2] = '{x: 16'd3329,  r: 16'd0,    err: 1'b1};
      tbl[3] = '{x: 16'd6657,  r: 16'd3328, err: 1'b1};
      tbl[4] = '{x: 16'd6658,  r: 16'd0,    err: 1'b1};
      tbl[5] = '{x: 16'd65535, r: 16'd0,    err: 1'b1};
      tbl[6] = '{x: 16'd1234,  r: 16'd1234, err: 1'b0};
      tbl[7] = '{x: 16'd3330,  r: 16'd1,    err: 1'b1};

      #2 rst = 1'b0;
      #1 check("reset_state", 64'({s_ready, we, address_ina, address_inb, data_ina, data_inb,
                                   start, mode, busy, err_range, err_len}), 64'(0));
      repeat (3) @(negedge clk);
      rst = 1'b1;

      go(1'b0); send(0, N, N-1, 0, 1'b1); finish_poly(50, 1'b0, 1'b0);   // full ramp
      go(1'b0); send(1, N, N-1, 0, 1'b1); finish_poly(8, 1'b1, 1'b0);    // reduction table, cmd_go in WAIT
      go(1'b0); send(0, N, 9, 0, 1'b1);   finish_poly(5, 1'b0, 1'b0);    // early last, odd index
      go(1'b1); send(2, N, 20, 30, 1'b1); finish_poly(0, 1'b0, 1'b1);    // early last, even index, done pre-high
      go(1'b1); send(2, N, N-1, 40, 1'b1); finish_poly(5, 1'b0, 1'b0);   // random gaps and values
      go(1'b0); send(0, N, N, 0, 1'b1);   finish_poly(3, 1'b0, 1'b0);    // no s_last at all
      go(1'b1); send(0, N, N-2, 0, 1'b1); finish_poly(3, 1'b0, 1'b0);    // last on N-2

      // Reset in the middle of a load, then a clean mode=1 load.
      go(1'b1);
      send(0, 37, N, 0, 1'b0);
      sc0 = start_cnt;
      #2 rst = 1'b0;
      #1 check("reset_mid", 64'({s_ready, we, address_ina, address_inb, data_ina, data_inb,
                                 start, mode, busy, err_range, err_len}), 64'(0));
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("no_start_after_reset", 64'(start_cnt), 64'(sc0));
      go(1'b1); send(0, N, N-1, 0, 1'b1); finish_poly(10, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
